// File: rtl/spike_event_reader.sv
// spike_event_reader: drains the spike event FIFO one word at a time.
// It splits the words into control markers (end of timestep, end of image)
// and spike events, and offers each spike to the neuron core over a
// valid/ready handshake. It also keeps a timestep index and a count of
// accepted events for the current image.
module spike_event_reader #(
  parameter int FIFO_WIDTH = 12,
  parameter int M          = 8,
  parameter int TS_BITS    = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RD_EN,
  input  logic [FIFO_WIDTH-1:0] FIFO_DATA,
  output logic                  EVT_VALID,
  input  logic                  EVT_READY,
  output logic [M-1:0]          EVT_ADDR,
  output logic                  TS_TICK,
  output logic [TS_BITS-1:0]    TIMESTEP,
  output logic [CNT_BITS-1:0]   EVT_COUNT,
  output logic                  DONE,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // The marker flags sit in the two top bits of the word.
  localparam int EOI_BIT = FIFO_WIDTH - 1;
  localparam int EOT_BIT = FIFO_WIDTH - 2;

  state_t              state_reg, state_next;
  logic                valid_reg, valid_next;
  logic [M-1:0]        addr_reg, addr_next;
  logic                tick_reg, tick_next;
  logic [TS_BITS-1:0]  ts_reg, ts_next;
  logic [CNT_BITS-1:0] count_reg, count_next;
  logic                done_reg, done_next;
  logic                rd_en;

  // Bits between the address and the flags carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^FIFO_DATA[EOT_BIT-1:M];

  // State register; reset returns to IDLE and drops any in-flight word.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, pop request and next values of every registered output.
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    addr_next  = addr_reg;
    tick_next  = 1'b0;
    ts_next    = ts_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          ts_next    = '0;
          count_next = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en = !FIFO_EMPTY;
        if (!FIFO_EMPTY) state_next = S_WAIT;
      end
      S_WAIT: begin
        // The word popped last cycle is on FIFO_DATA now.
        if (FIFO_DATA[EOI_BIT]) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (FIFO_DATA[EOT_BIT]) begin
          tick_next  = 1'b1;
          ts_next    = ts_reg + 1'b1;
          state_next = S_FETCH;
        end else begin
          addr_next  = FIFO_DATA[M-1:0];
          valid_next = 1'b1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (EVT_READY) begin
          valid_next = 1'b0;
          if (count_reg != {CNT_BITS{1'b1}}) count_next = count_reg + 1'b1;
          // Prefetch the next word in the accept cycle to keep one event
          // per two cycles when the core is always ready.
          rd_en      = !FIFO_EMPTY;
          state_next = FIFO_EMPTY ? S_FETCH : S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output and counter registers, all cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      tick_reg  <= 1'b0;
      ts_reg    <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      tick_reg  <= tick_next;
      ts_reg    <= ts_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  // The pop request is gated by reset so it is low during the reset cycle.
  assign FIFO_RD_EN = RST_N & rd_en;
  assign EVT_VALID  = valid_reg;
  assign EVT_ADDR   = addr_reg;
  assign TS_TICK    = tick_reg;
  assign TIMESTEP   = ts_reg;
  assign EVT_COUNT  = count_reg;
  assign DONE       = done_reg;
  assign BUSY       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_spike_event_reader.sv
// tb_spike_event_reader: a FIFO model feeds words to the reader. Every spike
// word pushed into the FIFO also pushes its address to an expected queue,
// and the monitor pops and compares the queue on each accepted event.
module tb_spike_event_reader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        FIFO_EMPTY;
  logic        FIFO_RD_EN;
  logic [11:0] FIFO_DATA = '0;
  logic        EVT_VALID;
  logic        EVT_READY = 1'b0;
  logic [7:0]  EVT_ADDR;
  logic        TS_TICK;
  logic [7:0]  TIMESTEP;
  logic [15:0] EVT_COUNT;
  logic        DONE;
  logic        BUSY;

  spike_event_reader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_EN(FIFO_RD_EN), .FIFO_DATA(FIFO_DATA), .EVT_VALID(EVT_VALID),
    .EVT_READY(EVT_READY), .EVT_ADDR(EVT_ADDR), .TS_TICK(TS_TICK),
    .TIMESTEP(TIMESTEP), .EVT_COUNT(EVT_COUNT), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // FIFO model: written by the stimulus, read by the DUT, one-cycle read latency.
  logic [11:0] fifo_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        hold_empty = 1'b0;
  assign FIFO_EMPTY = (rd_ptr == wr_ptr) || hold_empty;

  always @(posedge CLK) begin
    if (FIFO_RD_EN && (rd_ptr != wr_ptr)) begin
      FIFO_DATA <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor sampled on the falling edge, away from the active edge.
  int         rd_cnt = 0, tick_cnt = 0, done_cnt = 0;
  int         rd_viol = 0, stab_viol = 0, extra_evt = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] prev_addr = '0;

  always @(negedge CLK) begin
    if (FIFO_RD_EN && FIFO_EMPTY) rd_viol++;
    if (FIFO_RD_EN) rd_cnt++;
    if (TS_TICK) tick_cnt++;
    if (DONE) done_cnt++;
    if (RST_N && hold_prev && (!EVT_VALID || EVT_ADDR != prev_addr)) stab_viol++;
    if (RST_N && EVT_VALID && EVT_READY) begin
      if (exp_q.size() == 0) begin
        extra_evt++;
        $display("evt addr=%02h (not expected)", EVT_ADDR);
      end else begin
        $display("evt addr=%02h count=%0d", EVT_ADDR, EVT_COUNT);
        check("evt_addr", {24'd0, EVT_ADDR}, {24'd0, exp_q.pop_front()});
      end
    end
    hold_prev = RST_N && EVT_VALID && !EVT_READY;
    prev_addr = EVT_ADDR;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [11:0] w, input bit expect_it);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    if (expect_it && !w[11] && !w[10]) exp_q.push_back(w[7:0]);
  endtask

  task automatic start_image();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!DONE && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, DONE}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!EVT_VALID && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, {31'd0, EVT_VALID}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, {31'd0, FIFO_RD_EN}, 32'd0);
    check({tag, "_valid"}, {31'd0, EVT_VALID}, 32'd0);
    check({tag, "_addr"}, {24'd0, EVT_ADDR}, 32'd0);
    check({tag, "_tick"}, {31'd0, TS_TICK}, 32'd0);
    check({tag, "_ts"}, {24'd0, TIMESTEP}, 32'd0);
    check({tag, "_count"}, {16'd0, EVT_COUNT}, 32'd0);
    check({tag, "_done"}, {31'd0, DONE}, 32'd0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, tk0, dn0;

    // Reset state.
    RST_N = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    RST_N = 1'b1;
    tick();

    // Image 1: two events then EOI; start latency and pop count.
    push_word(12'h005, 1'b1);
    push_word(12'h0A3, 1'b1);
    push_word(12'h800, 1'b1);
    EVT_READY = 1'b1;
    rd0 = rd_cnt; dn0 = done_cnt;
    start_image();
    check("t1_busy_c1", {31'd0, BUSY}, 32'd1);
    check("t1_rd_en_c1", {31'd0, FIFO_RD_EN}, 32'd1);
    tick();
    check("t1_valid_c2", {31'd0, EVT_VALID}, 32'd0);
    tick();
    check("t1_valid_c3", {31'd0, EVT_VALID}, 32'd1);
    check("t1_addr_c3", {24'd0, EVT_ADDR}, 32'h05);
    wait_done("t1");
    check("t1_busy_after", {31'd0, BUSY}, 32'd0);
    check("t1_count", {16'd0, EVT_COUNT}, 32'd2);
    tick();
    check("t1_rd_pulses", rd_cnt - rd0, 32'd3);
    check("t1_done_pulses", done_cnt - dn0, 32'd1);
    check("t1_exp_left", exp_q.size(), 32'd0);

    // Image 2: timestep markers between events.
    push_word(12'h011, 1'b1);
    push_word(12'h400, 1'b1);
    push_word(12'h400, 1'b1);
    push_word(12'h022, 1'b1);
    push_word(12'h800, 1'b1);
    tk0 = tick_cnt;
    start_image();
    wait_done("t2");
    tick();
    check("t2_ticks", tick_cnt - tk0, 32'd2);
    check("t2_timestep", {24'd0, TIMESTEP}, 32'd2);
    check("t2_count", {16'd0, EVT_COUNT}, 32'd2);
    check("t2_exp_left", exp_q.size(), 32'd0);

    // Image 3: back-pressure on event 0x7F.
    push_word(12'h07F, 1'b1);
    push_word(12'h800, 1'b1);
    EVT_READY = 1'b0;
    start_image();
    wait_valid("t3");
    rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, EVT_VALID}, 32'd1);
      check("t3_hold_addr", {24'd0, EVT_ADDR}, 32'h7F);
      check("t3_hold_count", {16'd0, EVT_COUNT}, 32'd0);
    end
    check("t3_no_rd", rd_cnt - rd0, 32'd0);
    EVT_READY = 1'b1;
    tick();
    check("t3_count_accept", {16'd0, EVT_COUNT}, 32'd1);
    wait_done("t3");
    check("t3_count_final", {16'd0, EVT_COUNT}, 32'd1);
    tick();

    // Image 4: FIFO_EMPTY toggles randomly between events.
    push_word(12'h031, 1'b1);
    push_word(12'h032, 1'b1);
    push_word(12'h033, 1'b1);
    push_word(12'h800, 1'b1);
    start_image();
    begin
      int n = 0;
      while (!DONE && n < 300) begin
        hold_empty = ($urandom_range(0, 1) == 1);
        tick();
        n++;
      end
    end
    hold_empty = 1'b0;
    check("t4_done_seen", {31'd0, DONE}, 32'd1);
    check("t4_count", {16'd0, EVT_COUNT}, 32'd3);
    check("t4_exp_left", exp_q.size(), 32'd0);
    tick();

    // Image 5: combined EOI+EOT word ends the image without a tick.
    push_word(12'h400, 1'b1);
    push_word(12'h044, 1'b1);
    push_word(12'hC00, 1'b1);
    tk0 = tick_cnt; dn0 = done_cnt;
    start_image();
    wait_done("t5");
    tick();
    check("t5_ticks", tick_cnt - tk0, 32'd1);
    check("t5_timestep", {24'd0, TIMESTEP}, 32'd1);
    check("t5_done_pulses", done_cnt - dn0, 32'd1);
    check("t5_count", {16'd0, EVT_COUNT}, 32'd1);

    // Image 6: reset while an event is offered, then a fresh image.
    push_word(12'h033, 1'b0);
    EVT_READY = 1'b0;
    tk0 = tick_cnt; dn0 = done_cnt;
    start_image();
    wait_valid("t6");
    RST_N = 1'b0;
    tick();
    check_idle_outputs("t6_rst");
    RST_N = 1'b1;
    tick();
    check("t6_no_done", done_cnt - dn0, 32'd0);
    check("t6_no_tick", tick_cnt - tk0, 32'd0);
    check("t6_busy_after", {31'd0, BUSY}, 32'd0);
    push_word(12'h055, 1'b1);
    push_word(12'h800, 1'b1);
    EVT_READY = 1'b1;
    start_image();
    wait_done("t6");
    check("t6_count", {16'd0, EVT_COUNT}, 32'd1);
    tick();
    check("t6_exp_left", exp_q.size(), 32'd0);

    // Protocol properties collected across the whole run.
    check("rd_en_while_empty", rd_viol, 32'd0);
    check("valid_addr_stability", stab_viol, 32'd0);
    check("unexpected_events", extra_evt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_reader.md
# spike_event_reader

Read-side consumer of the spike event FIFO. It pops 12-bit event words, separates control markers from spike events, and presents each spike to the neuron core over a valid/ready handshake. It also tracks timesteps and counts forwarded events for the current image. It sits between the event FIFO read port and the neuron core input.

## Interface
- FIFO_WIDTH, default 12: event word width.
- M, default 8: neuron address bits, covering N = 256 neurons.
- TS_BITS, default 8: timestep counter width.
- CNT_BITS, default 16: event counter width.
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  reset; synchronous, active-low.
- START  in  1  begin draining for a new image; sampled only in IDLE.
- FIFO_EMPTY  in  1  FIFO has no readable word.
- FIFO_RD_EN  out  1  pop request; FIFO_DATA is valid exactly one cycle later.
- FIFO_DATA  in  FIFO_WIDTH  event word. Bit 11 = EOI (end of image), bit 10 = EOT (end of timestep), bits 9:8 ignored, bits 7:0 = neuron address.
- EVT_VALID  out  1  spike event offered to the neuron core.
- EVT_READY  in  1  neuron core accepts the event.
- EVT_ADDR  out  M  neuron address of the offered event.
- TS_TICK  out  1  one-cycle pulse per consumed EOT marker.
- TIMESTEP  out  TS_BITS  current timestep index.
- EVT_COUNT  out  CNT_BITS  number of events accepted by the core in this image.
- DONE  out  1  one-cycle pulse when an EOI marker is consumed.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States are IDLE, FETCH, WAIT and OUT.
- IDLE
  - On START: clear TIMESTEP and EVT_COUNT, then go to FETCH.
  - START is ignored in all other states.
- FETCH
  - FIFO_RD_EN = !FIFO_EMPTY, combinational from state.
  - If FIFO_RD_EN is high, go to WAIT; otherwise stay in FETCH.
- WAIT: capture and decode FIFO_DATA.
  - EOI set, regardless of EOT: DONE pulses the next cycle, go to IDLE. The word is not forwarded and TIMESTEP is unchanged.
  - EOT set, EOI clear: TS_TICK pulses the next cycle, TIMESTEP += 1 (wraps modulo 2^TS_BITS), go to FETCH. The word is not forwarded.
  - Neither set: EVT_ADDR <= bits 7:0, EVT_VALID <= 1, go to OUT.
- OUT: hold EVT_VALID and EVT_ADDR stable until EVT_READY.
  - On EVT_READY, EVT_COUNT += 1, saturating at 2^CNT_BITS-1.
  - On EVT_READY with FIFO not empty: EVT_VALID drops next cycle, FIFO_RD_EN = 1 this cycle, go to WAIT (back-to-back prefetch).
  - On EVT_READY with FIFO empty: EVT_VALID drops next cycle, go to FETCH.
- FIFO_RD_EN is never asserted when FIFO_EMPTY = 1, and never in IDLE or WAIT.
- Only one word is in flight at a time; no internal buffering beyond the EVT_ADDR register.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. FIFO_RD_EN is 0 in the reset cycle.
- Reset mid-operation: any in-flight FIFO word or offered event is dropped. DONE and TS_TICK do not pulse.
- Start latency: START high at cycle c gives FETCH at c+1. With FIFO non-empty, FIFO_RD_EN is high at c+1, WAIT at c+2, and EVT_VALID is high from c+3.
- Steady-state throughput with EVT_READY tied high and FIFO non-empty is one event per 2 cycles.
- EVT_COUNT, TIMESTEP, TS_TICK and DONE are registered and update the cycle after the triggering edge.
- EVT_VALID must not drop before EVT_READY, and EVT_ADDR must not change while EVT_VALID is high.
- After DONE, the next START may be given in the cycle after DONE.

## Test plan
- Reset, then START; FIFO holds 0x005, 0x0A3, 0x800 with EVT_READY = 1 -> events 0x05 then 0xA3; EVT_COUNT = 2; DONE pulses once; BUSY low after DONE; FIFO_RD_EN pulsed exactly 3 times.
- FIFO holds 0x011, 0x400, 0x400, 0x022, 0x800 -> two TS_TICK pulses; TIMESTEP = 2; events 0x11 and 0x22 only.
- EVT_READY held low for 5 cycles on event 0x7F -> EVT_VALID/EVT_ADDR stable for 5 cycles; no FIFO_RD_EN meanwhile; EVT_COUNT increments once, on acceptance.
- FIFO_EMPTY toggles between events -> FIFO_RD_EN never high while empty; waits in FETCH; no lost or duplicated events.
- Word 0xC00 (EOI and EOT both set) -> DONE pulses; no TS_TICK; TIMESTEP unchanged.
- Apply RST_N = 0 while in OUT -> next cycle all outputs 0 and state IDLE; a new START then processes a fresh image.
